// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle main controller:
//   state_t    - 4-bit state encoding (FETCH=0 ... BRANCH=9), also exported
//                on the State debug output
//   OP_*       - instruction Op field values
//   RES_*      - ResultSrc mux encodings
//   SRCB_*     - ALUSrcB mux encodings
//   ctrl_t     - state-decoded control word produced by mc_out_decode
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_main_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_main_fsm_if
// Bundles the controller's instruction/memory inputs and control outputs.
//   master : instruction/memory side (drives Op, Funct, MemReady; reads
//            control outputs)
//   slave  : the controller mc_main_fsm
// Op/Funct are instruction bits [27:26]/[25:20]; MemReady means the memory
// transfer completes this cycle. State is the raw state encoding (debug).
// ---------------------------------------------------------------------------
interface mc_main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ALUOp;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, Illegal, State
    );

    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, Illegal, State
    );
endinterface

// File: rtl/mc_out_decode.sv
// ---------------------------------------------------------------------------
// mc_out_decode
// Pure combinational decode of the current state into the Moore control word.
//   state : current state encoding (raw 4 bits so that unused encodings
//           10..15 decode to an all-zero word)
//   ctrl  : control word; fields not named for a state are 0
// ---------------------------------------------------------------------------
module mc_out_decode
    import mc_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.irwrite   = 1'b1;
                ctrl.nextpc    = 1'b1;
                ctrl.adrsrc    = 1'b0;
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            DECODE: begin
                ctrl.alusrca   = 1'b1;
                ctrl.alusrcb   = SRCB_FOUR;
                ctrl.resultsrc = RES_ALURESULT;
            end
            MEMADR: begin
                ctrl.alusrca   = 1'b0;
                ctrl.alusrcb   = SRCB_EXTIMM;
                ctrl.aluop     = 1'b0;
            end
            MEMRD: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.resultsrc = RES_DATA;
                ctrl.regw      = 1'b1;
            end
            MEMWR: begin
                ctrl.adrsrc    = 1'b1;
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.memw      = 1'b1;
            end
            EXECUTER: begin
                ctrl.alusrca   = 1'b0;
                ctrl.alusrcb   = SRCB_REG;
                ctrl.aluop     = 1'b1;
            end
            EXECUTEI: begin
                ctrl.alusrca   = 1'b0;
                ctrl.alusrcb   = SRCB_EXTIMM;
                ctrl.aluop     = 1'b1;
            end
            ALUWB: begin
                ctrl.resultsrc = RES_ALUOUT;
                ctrl.regw      = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca   = 1'b0;
                ctrl.alusrcb   = SRCB_EXTIMM;
                ctrl.resultsrc = RES_ALURESULT;
                ctrl.branch    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_fsm.sv
// ---------------------------------------------------------------------------
// mc_main_fsm
// Main controller of a multi-cycle processor: state register, next-state
// logic and output gating. Control outputs are decoded from the current
// state by mc_out_decode.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; next state forced to FETCH and all
//           write enables / Illegal held at 0 while asserted
//   bus   : mc_main_fsm_if.slave (Op, Funct, MemReady in; control out)
//
// Build option: define MC_FSM_MEMWAIT_EN to make FETCH, MEMRD and MEMWR wait
// for MemReady. Without it MemReady is treated as always 1.
//
// Handshake: a memory state completes on a cycle where MemReady=1; while it
// is 0 the state holds. A held FETCH suppresses IRWrite/NextPC so the PC and
// instruction register only load on the completing cycle; a held MEMWR keeps
// MemW asserted for the whole transfer.
// ---------------------------------------------------------------------------
module mc_main_fsm
    import mc_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mc_main_fsm_if.slave  bus
);

`ifdef MC_FSM_MEMWAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    state_t state;
    ctrl_t  ctrl;
    logic   mem_ready;
    logic   held_fetch;
    logic   unused_funct;

    // With wait states disabled every transfer completes immediately.
    assign mem_ready    = bus.MemReady | ~WAIT_EN;
    // Funct[4:1] only matter to the datapath, not to sequencing.
    assign unused_funct = ^bus.Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (bus.Op)
                        OP_MEM:  state <= MEMADR;
                        OP_DP:   state <= bus.Funct[5] ? EXECUTEI : EXECUTER;
                        OP_BR:   state <= BRANCH;
                        default: state <= FETCH;   // undefined Op: abandon
                    endcase
                end
                MEMADR:   state <= bus.Funct[0] ? MEMRD : MEMWR;
                MEMRD:    if (mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWR:    if (mem_ready) state <= FETCH;
                EXECUTER: state <= ALUWB;
                EXECUTEI: state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                default:  state <= FETCH;          // unreachable encodings
            endcase
        end
    end

    mc_out_decode u_out_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign held_fetch = (state == FETCH) && !mem_ready;

    // Write enables are killed during reset so an abandoned instruction
    // never leaves a partial write behind.
    assign bus.IRWrite   = ctrl.irwrite & ~held_fetch & ~reset;
    assign bus.NextPC    = ctrl.nextpc  & ~held_fetch & ~reset;
    assign bus.RegW      = ctrl.regw    & ~reset;
    assign bus.MemW      = ctrl.memw    & ~reset;
    assign bus.Branch    = ctrl.branch  & ~reset;
    assign bus.AdrSrc    = ctrl.adrsrc;
    assign bus.ResultSrc = ctrl.resultsrc;
    assign bus.ALUSrcA   = ctrl.alusrca;
    assign bus.ALUSrcB   = ctrl.alusrcb;
    assign bus.ALUOp     = ctrl.aluop;
    assign bus.Illegal   = (state == DECODE) && (bus.Op == OP_UNDEF) && !reset;
    assign bus.State     = state;

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20].
- MemReady  in  1  memory transfer completes this cycle.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  write PC (unconditional).
- RegW  out  1  raw register-write request (pre-condition-check).
- MemW  out  1  raw memory-write request (pre-condition-check).
- Branch  out  1  raw branch request (pre-condition-check).
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  ALU A: 0 = register, 1 = PC.
- ALUSrcB  out  2  ALU B: 00 = register, 01 = ExtImm, 10 = constant 4.
- ALUOp  out  1  1 = ALU function from Funct, 0 = ADD.
- Illegal  out  1  one-cycle pulse on undefined Op.
- State  out  4  current state encoding (debug).

Function
REQ-002 The block SHALL be a Moore FSM: all outputs are decoded from the current state only. Outputs not listed for a state are 0.
REQ-003 FETCH SHALL drive IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, and go to DECODE.
REQ-004 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, and go to:
- MEMADR if Op=01.
- EXECUTER if Op=00 and Funct[5]=0.
- EXECUTEI if Op=00 and Funct[5]=1.
- BRANCH if Op=10.
REQ-005 On Op=11 in DECODE, the block SHALL assert Illegal for that one cycle and go to FETCH.
REQ-006 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=0, and go to MEMRD if Funct[0]=1, else MEMWR.
REQ-007 MEMRD SHALL drive AdrSrc=1, ResultSrc=00, and go to MEMWB.
REQ-008 MEMWB SHALL drive ResultSrc=01, RegW=1, and go to FETCH.
REQ-009 MEMWR SHALL drive AdrSrc=1, ResultSrc=00, MemW=1, and go to FETCH.
REQ-010 EXECUTER SHALL drive ALUSrcA=0, ALUSrcB=00, ALUOp=1. EXECUTEI SHALL drive ALUSrcA=0, ALUSrcB=01, ALUOp=1. Both SHALL go to ALUWB.
REQ-011 ALUWB SHALL drive ResultSrc=00, RegW=1, and go to FETCH.
REQ-012 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, and go to FETCH.
REQ-013 Latency without wait states SHALL be: LDR 5 cycles, STR 4, data-processing 4, B 3, undefined 2.
REQ-014 An unreachable state encoding SHALL go to FETCH on the next edge with all outputs 0.

Reset
REQ-015 While reset=1, the block SHALL force the next state to FETCH. IRWrite, NextPC, RegW, MemW, Branch and Illegal SHALL be 0 regardless of state.
REQ-016 Reset asserted mid-instruction (any state) SHALL abandon the instruction with no write-enable pulse. FETCH SHALL be active in the first cycle after reset deasserts.

Configuration
REQ-017 Macro MC_FSM_MEMWAIT_EN SHALL control wait-state support:
- Defined: FETCH, MEMRD and MEMWR SHALL hold their state while MemReady=0. In a held FETCH, IRWrite and NextPC SHALL be 0. In a held MEMWR, MemW SHALL stay 1. The state SHALL advance on the first cycle with MemReady=1.
- Undefined: MemReady SHALL be ignored and treated as 1.

Structure
REQ-018 Package mc_pkg SHALL hold:
- the 4-bit state enum (FETCH=0 ... BRANCH=9);
- Op constants OP_DP=00, OP_MEM=01, OP_BR=10;
- ResultSrc and ALUSrcB encodings.
REQ-019 One sub-module, mc_out_decode (combinational, state to control word), SHALL be instantiated. The state register and next-state logic SHALL remain in mc_main_fsm.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset 2 cycles, release, Op=00 Funct=000000 -> State FETCH,DECODE,EXECUTER,ALUWB,FETCH; RegW=1 only in cycle 4.
- Op=01 Funct[0]=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; ResultSrc=01 and RegW=1 in cycle 5.
- Op=01 Funct[0]=0 with MEMWAIT_EN, MemReady low 3 cycles in MEMWR -> MemW=1 for 4 cycles, then FETCH.
- Op=10 -> Branch=1 in cycle 3 with ALUSrcB=01; FETCH in cycle 4.
- Op=11 -> Illegal=1 exactly one cycle in DECODE, then FETCH, no write-enable asserted.
- Reset asserted in MEMADR -> FETCH next cycle; MemW and RegW never asserted.
